// File: rtl/stream_channel_scoreboard.sv
// ---------------------------------------------------------------------------
// stream_channel_scoreboard
//   Passive scoreboard for NumChan independent valid/ready streams. Every
//   ingress-side handshake (a_*) enqueues its payload as an expected entry.
//   Every egress-side handshake (b_*) pops the head entry and compares it
//   with the received payload. Per channel it keeps match/mismatch counters,
//   sticky overflow/underflow/timeout flags and the occupancy. Globally it
//   captures the first mismatch seen.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   clear_i                 zero stats/flags/capture (FIFO contents kept)
//   a_valid_i/a_ready_i     ingress handshake snoop, one bit per channel
//   a_data_i                ingress payload, channel c at [c*DataWidth +: DataWidth]
//   b_valid_i/b_ready_i     egress handshake snoop, one bit per channel
//   b_data_i                egress payload, same packing
//   level_o                 per-channel FIFO occupancy
//   match_cnt_o             per-channel saturating match counters
//   mismatch_cnt_o          per-channel saturating mismatch counters
//   overflow_o/underflow_o/timeout_o  per-channel sticky flags
//   first_err_*_o           capture of the first mismatch
//   err_o                   any error present in registered state
// ---------------------------------------------------------------------------

// Per-channel expected-entry FIFO, comparator, counters and age tracker.
module stream_channel_scoreboard_chan #(
    parameter int DataWidth     = 64,
    parameter int Depth         = 8,
    parameter int CntWidth      = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_req_i,
    input  logic [DataWidth-1:0]         a_data_i,
    input  logic [DataWidth-1:0]         b_data_i,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic [CntWidth-1:0]          match_cnt_o,
    output logic [CntWidth-1:0]          mismatch_cnt_o,
    output logic                         overflow_o,
    output logic                         underflow_o,
    output logic                         timeout_o,
    output logic                         mismatch_ev_o,
    output logic [DataWidth-1:0]         head_o,
    output logic                         err_o
);
    localparam int LvlW = $clog2(Depth + 1);
    localparam int PtrW = $clog2(Depth);
    localparam int AgeW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);
    localparam logic [AgeW-1:0] AgeMax  = AgeW'(TimeoutCycles);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]      level_q, level_d;
    logic [AgeW-1:0]      age_q, age_d;
    logic [CntWidth-1:0]  match_q, match_d, mism_q, mism_d;
    logic                 ovf_q, unf_q, tmo_q;
    logic                 empty, full, pop, push_ok;
    logic                 ev_match, ev_mism, ev_ovf, ev_unf, ev_tmo;

    assign head_o = mem_q[rd_ptr_q];

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LvlFull);
        pop      = pop_req_i && !empty;
        // A push into a full FIFO still lands when a pop frees the head slot.
        push_ok  = push_i && (!full || pop);
        ev_match = pop && (head_o == b_data_i);
        ev_mism  = pop && (head_o != b_data_i);
        ev_ovf   = push_i && full && !pop;
        ev_unf   = pop_req_i && empty;

        level_d = level_q;
        if (push_ok && !pop) level_d = level_q + LvlW'(1);
        else if (pop && !push_ok) level_d = level_q - LvlW'(1);

        // Age measures how long the current head has waited.
        age_d = age_q;
        if (empty || pop)        age_d = '0;
        else if (age_q != AgeMax) age_d = age_q + AgeW'(1);
        ev_tmo = (TimeoutCycles != 0) && (age_d == AgeMax);

        match_d = (ev_match && !(&match_q)) ? match_q + CntWidth'(1) : match_q;
        mism_d  = (ev_mism  && !(&mism_q))  ? mism_q  + CntWidth'(1) : mism_q;
    end

    // Storage has no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= a_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            age_q    <= '0;
            match_q  <= '0;
            mism_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_d;
            age_q   <= age_d;
            if (clear_i) begin
                match_q <= '0;
                mism_q  <= '0;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                match_q <= match_d;
                mism_q  <= mism_d;
                ovf_q   <= ovf_q | ev_ovf;
                unf_q   <= unf_q | ev_unf;
                tmo_q   <= tmo_q | ev_tmo;
            end
        end
    end

    assign level_o        = level_q;
    assign match_cnt_o    = match_q;
    assign mismatch_cnt_o = mism_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign timeout_o      = tmo_q;
    assign mismatch_ev_o  = ev_mism;
    assign err_o          = (mism_q != '0) | ovf_q | unf_q | tmo_q;
endmodule

module stream_channel_scoreboard #(
    parameter int NumChan       = 5,
    parameter int DataWidth     = 64,
    parameter int Depth         = 8,
    parameter int CntWidth      = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clear_i,
    input  logic [NumChan-1:0]                        a_valid_i,
    input  logic [NumChan-1:0]                        a_ready_i,
    input  logic [NumChan*DataWidth-1:0]              a_data_i,
    input  logic [NumChan-1:0]                        b_valid_i,
    input  logic [NumChan-1:0]                        b_ready_i,
    input  logic [NumChan*DataWidth-1:0]              b_data_i,
    output logic [NumChan*$clog2(Depth+1)-1:0]        level_o,
    output logic [NumChan*CntWidth-1:0]               match_cnt_o,
    output logic [NumChan*CntWidth-1:0]               mismatch_cnt_o,
    output logic [NumChan-1:0]                        overflow_o,
    output logic [NumChan-1:0]                        underflow_o,
    output logic [NumChan-1:0]                        timeout_o,
    output logic                                      first_err_valid_o,
    output logic [((NumChan > 1) ? $clog2(NumChan) : 1)-1:0] first_err_chan_o,
    output logic [DataWidth-1:0]                      first_err_exp_o,
    output logic [DataWidth-1:0]                      first_err_got_o,
    output logic                                      err_o
);
    localparam int LvlW = $clog2(Depth + 1);
    localparam int ChW  = (NumChan > 1) ? $clog2(NumChan) : 1;

    logic [NumChan-1:0]                mism_ev, ch_err;
    logic [NumChan-1:0][DataWidth-1:0] head;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        stream_channel_scoreboard_chan #(
            .DataWidth    (DataWidth),
            .Depth        (Depth),
            .CntWidth     (CntWidth),
            .TimeoutCycles(TimeoutCycles)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .clear_i       (clear_i),
            .push_i        (a_valid_i[c] & a_ready_i[c]),
            .pop_req_i     (b_valid_i[c] & b_ready_i[c]),
            .a_data_i      (a_data_i[c*DataWidth +: DataWidth]),
            .b_data_i      (b_data_i[c*DataWidth +: DataWidth]),
            .level_o       (level_o[c*LvlW +: LvlW]),
            .match_cnt_o   (match_cnt_o[c*CntWidth +: CntWidth]),
            .mismatch_cnt_o(mismatch_cnt_o[c*CntWidth +: CntWidth]),
            .overflow_o    (overflow_o[c]),
            .underflow_o   (underflow_o[c]),
            .timeout_o     (timeout_o[c]),
            .mismatch_ev_o (mism_ev[c]),
            .head_o        (head[c]),
            .err_o         (ch_err[c])
        );
    end

    logic                 fe_valid_q;
    logic [ChW-1:0]       fe_chan_q, sel_chan;
    logic [DataWidth-1:0] fe_exp_q, fe_got_q, sel_exp, sel_got;

    // Walk downward so the lowest mismatching channel wins.
    always_comb begin
        sel_chan = '0;
        for (int c = NumChan - 1; c >= 0; c--) begin
            if (mism_ev[c]) sel_chan = ChW'(c);
        end
        sel_exp = head[sel_chan];
        sel_got = b_data_i[sel_chan*DataWidth +: DataWidth];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            fe_valid_q <= 1'b0;
            fe_chan_q  <= '0;
            fe_exp_q   <= '0;
            fe_got_q   <= '0;
        end else if (!fe_valid_q && (|mism_ev)) begin
            fe_valid_q <= 1'b1;
            fe_chan_q  <= sel_chan;
            fe_exp_q   <= sel_exp;
            fe_got_q   <= sel_got;
        end
    end

    assign first_err_valid_o = fe_valid_q;
    assign first_err_chan_o  = fe_chan_q;
    assign first_err_exp_o   = fe_exp_q;
    assign first_err_got_o   = fe_got_q;
    assign err_o             = |ch_err;
endmodule

// File: tb/tb_stream_channel_scoreboard.sv
module tb_stream_channel_scoreboard;
    localparam int NC = 5;
    localparam int DW = 64;
    localparam int DP = 8;
    localparam int CW = 16;
    localparam int TO = 4;
    localparam int LW = $clog2(DP + 1);

    typedef enum int {K_LVL, K_MATCH, K_MISM, K_OVF, K_UNF, K_TMO,
                      K_FEV, K_FECH, K_FEEXP, K_FEGOT, K_ERR} kind_e;
    typedef struct {
        string       nm;
        kind_e       k;
        int          c;
        logic [63:0] v;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [NC-1:0]     a_v = '0, a_r = '0, b_v = '0, b_r = '0;
    logic [NC*DW-1:0]  a_d = '0, b_d = '0;
    logic [NC*LW-1:0]  level;
    logic [NC*CW-1:0]  mcnt, mmcnt;
    logic [NC-1:0]     ovf, unf, tmo;
    logic              fev, err;
    logic [2:0]        fech;
    logic [DW-1:0]     feexp, fegot;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    stream_channel_scoreboard #(
        .NumChan(NC), .DataWidth(DW), .Depth(DP), .CntWidth(CW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .a_valid_i(a_v), .a_ready_i(a_r), .a_data_i(a_d),
        .b_valid_i(b_v), .b_ready_i(b_r), .b_data_i(b_d),
        .level_o(level), .match_cnt_o(mcnt), .mismatch_cnt_o(mmcnt),
        .overflow_o(ovf), .underflow_o(unf), .timeout_o(tmo),
        .first_err_valid_o(fev), .first_err_chan_o(fech),
        .first_err_exp_o(feexp), .first_err_got_o(fegot), .err_o(err)
    );

    function automatic logic [63:0] dut_val(kind_e k, int c);
        case (k)
            K_LVL:   return 64'(level[c*LW +: LW]);
            K_MATCH: return 64'(mcnt[c*CW +: CW]);
            K_MISM:  return 64'(mmcnt[c*CW +: CW]);
            K_OVF:   return 64'(ovf[c]);
            K_UNF:   return 64'(unf[c]);
            K_TMO:   return 64'(tmo[c]);
            K_FEV:   return 64'(fev);
            K_FECH:  return 64'(fech);
            K_FEEXP: return feexp;
            K_FEGOT: return fegot;
            default: return 64'(err);
        endcase
    endfunction

    // Monitor: outputs only move on posedge, so everything queued since the
    // last edge is compared on the following negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e = q.pop_front();
            act = dut_val(e.k, e.c);
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, act, e.v);
        end
    end

    task automatic exp(string nm, kind_e k, int c, logic [63:0] v);
        exp_t e;
        e.nm = nm; e.k = k; e.c = c; e.v = v;
        q.push_back(e);
    endtask

    task automatic push(int c, logic [63:0] d);
        a_v[c] = 1'b1; a_r[c] = 1'b1; a_d[c*DW +: DW] = d;
    endtask

    task automatic pop(int c, logic [63:0] d);
        b_v[c] = 1'b1; b_r[c] = 1'b1; b_d[c*DW +: DW] = d;
    endtask

    // One clock: inputs set beforehand are sampled, then withdrawn.
    task automatic cyc();
        @(posedge clk);
        #1;
        a_v = '0; a_r = '0; b_v = '0; b_r = '0; clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        exp("rst_level0", K_LVL, 0, 0);
        exp("rst_level4", K_LVL, 4, 0);
        exp("rst_err", K_ERR, 0, 0);
        exp("rst_fev", K_FEV, 0, 0);

        // Basic match on ch0
        push(0, 64'hA5); cyc();
        exp("t1_level_after_push", K_LVL, 0, 1);
        pop(0, 64'hA5); cyc();
        exp("t1_level_after_pop", K_LVL, 0, 0);
        exp("t1_match0", K_MATCH, 0, 1);
        exp("t1_mism0", K_MISM, 0, 0);
        exp("t1_err", K_ERR, 0, 0);
        a_v[0] = 1'b1; a_d[63:0] = 64'hDEAD; cyc();
        exp("t1_valid_no_ready", K_LVL, 0, 0);

        // Mismatch on ch2 and capture
        push(2, 64'h11); cyc();
        pop(2, 64'h22); cyc();
        exp("t2_mism2", K_MISM, 2, 1);
        exp("t2_match2", K_MATCH, 2, 0);
        exp("t2_fev", K_FEV, 0, 1);
        exp("t2_fech", K_FECH, 0, 2);
        exp("t2_feexp", K_FEEXP, 0, 64'h11);
        exp("t2_fegot", K_FEGOT, 0, 64'h22);
        exp("t2_err", K_ERR, 0, 1);
        push(2, 64'h33); cyc();
        pop(2, 64'h44); cyc();
        exp("t2_mism2_second", K_MISM, 2, 2);
        exp("t2_feexp_held", K_FEEXP, 0, 64'h11);
        exp("t2_fegot_held", K_FEGOT, 0, 64'h22);
        clr = 1'b1; cyc();
        exp("t2_clr_mism2", K_MISM, 2, 0);
        exp("t2_clr_fev", K_FEV, 0, 0);
        exp("t2_clr_feexp", K_FEEXP, 0, 0);
        exp("t2_clr_err", K_ERR, 0, 0);

        // Overflow on ch3, then full with simultaneous push/pop
        for (int i = 0; i < 9; i++) begin
            push(3, 64'h100 + 64'(i)); cyc();
        end
        exp("t3_level_full", K_LVL, 3, 8);
        exp("t3_ovf", K_OVF, 3, 1);
        exp("t3_match3", K_MATCH, 3, 0);
        clr = 1'b1; cyc();
        exp("t3_clr_ovf", K_OVF, 3, 0);
        push(3, 64'h200); pop(3, 64'h100); cyc();
        exp("t3_full_pushpop_level", K_LVL, 3, 8);
        exp("t3_full_pushpop_ovf", K_OVF, 3, 0);
        exp("t3_full_pushpop_match", K_MATCH, 3, 1);
        exp("t3_full_pushpop_mism", K_MISM, 3, 0);
        // Reset mid-traffic, with a push in the same cycle that must be lost
        rst = 1'b1; push(0, 64'h77); cyc();
        rst = 1'b0;
        exp("t3_rst_level3", K_LVL, 3, 0);
        exp("t3_rst_level0", K_LVL, 0, 0);
        exp("t3_rst_match3", K_MATCH, 3, 0);
        exp("t3_rst_tmo3", K_TMO, 3, 0);
        exp("t3_rst_err", K_ERR, 0, 0);

        // Underflow on ch1 with simultaneous push
        push(1, 64'h55); pop(1, 64'h99); cyc();
        exp("t4_unf1", K_UNF, 1, 1);
        exp("t4_level1", K_LVL, 1, 1);
        exp("t4_match1", K_MATCH, 1, 0);
        exp("t4_mism1", K_MISM, 1, 0);
        exp("t4_err", K_ERR, 0, 1);
        pop(1, 64'h55); cyc();
        exp("t4_match1_drain", K_MATCH, 1, 1);
        exp("t4_level1_drain", K_LVL, 1, 0);
        clr = 1'b1; cyc();
        exp("t4_clr_unf1", K_UNF, 1, 0);
        exp("t4_clr_err", K_ERR, 0, 0);

        // Timeout on ch4 (TimeoutCycles=4)
        push(4, 64'hC0); cyc();
        cyc(); cyc(); cyc();
        exp("t5_tmo_age3", K_TMO, 4, 0);
        exp("t5_level4", K_LVL, 4, 1);
        cyc();
        exp("t5_tmo_age4", K_TMO, 4, 1);
        exp("t5_err", K_ERR, 0, 1);
        pop(4, 64'hC0); cyc();
        exp("t5_match4", K_MATCH, 4, 1);
        clr = 1'b1; cyc();
        exp("t5_clr_tmo", K_TMO, 4, 0);
        push(4, 64'hC1); cyc();
        cyc(); cyc(); cyc();
        pop(4, 64'hC1); cyc();
        cyc(); cyc();
        exp("t5_pop_age3_tmo", K_TMO, 4, 0);
        exp("t5_pop_age3_match", K_MATCH, 4, 1);
        exp("t5_pop_age3_level", K_LVL, 4, 0);
        exp("t5_pop_age3_err", K_ERR, 0, 0);

        // Simultaneous mismatches on ch1 and ch3
        push(0, 64'h5); push(1, 64'hAAAA); push(3, 64'hBBBB); cyc();
        pop(1, 64'h1); pop(3, 64'h2); cyc();
        exp("t6_mism1", K_MISM, 1, 1);
        exp("t6_mism3", K_MISM, 3, 1);
        exp("t6_fech", K_FECH, 0, 1);
        exp("t6_feexp", K_FEEXP, 0, 64'hAAAA);
        exp("t6_fegot", K_FEGOT, 0, 64'h1);
        exp("t6_level0", K_LVL, 0, 1);
        clr = 1'b1; cyc();
        exp("t6_clr_mism1", K_MISM, 1, 0);
        exp("t6_clr_mism3", K_MISM, 3, 0);
        exp("t6_clr_fev", K_FEV, 0, 0);
        exp("t6_clr_fech", K_FECH, 0, 0);
        exp("t6_clr_err", K_ERR, 0, 0);
        exp("t6_clr_level0_kept", K_LVL, 0, 1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        exp("t6_rst_level0", K_LVL, 0, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
